// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life generation scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package life_pkg;

    localparam int ROWS   = 720;   // grid rows
    localparam int COLS   = 1280;  // grid columns (one BRAM row word)
    localparam int ROW_AW = 10;    // row address width

    // Scheduler FSM states
    typedef enum logic [3:0] {
        IDLE,
        PRE0,
        PRE1,
        PRE2,
        PWAIT,
        COMP,
        WRITE,
        FETCH,
        DONE
    } sched_state_t;

    // Write-port source select
    localparam logic WR_SRC_GEN  = 1'b0;
    localparam logic WR_SRC_HOST = 1'b1;

endpackage

// File: rtl/life_gen_scheduler_if.sv
// Bundle of control, BRAM-port and compute-handshake signals around the scheduler.
// Latency: n/a (wiring only).
// Backpressure: compute side stalls the scheduler via cmp_ready; host side waits for init_gnt.
// master = scheduler, slave = surrounding fabric (BRAM, row-compute unit, host loader, packer).
interface life_gen_scheduler_if #(
    parameter int ROW_AW = 10
);
    logic              frame_start;
    logic              pause;
    logic              step_req;
    logic              init_req;
    logic              init_gnt;
    logic              init_we;
    logic [ROW_AW-1:0] init_addr;
    logic              rd_en;
    logic [ROW_AW-1:0] rd_addr;
    logic              win_shift;
    logic              cmp_valid;
    logic [ROW_AW-1:0] cmp_row;
    logic              cmp_ready;
    logic              wr_en;
    logic [ROW_AW-1:0] wr_addr;
    logic              wr_bank;
    logic              wr_src;
    logic              front_bank;
    logic              gen_busy;
    logic [31:0]       gen_count;

    modport master (
        input  frame_start, pause, step_req, init_req, init_we, init_addr, cmp_ready,
        output init_gnt, rd_en, rd_addr, win_shift, cmp_valid, cmp_row,
               wr_en, wr_addr, wr_bank, wr_src, front_bank, gen_busy, gen_count
    );

    modport slave (
        output frame_start, pause, step_req, init_req, init_we, init_addr, cmp_ready,
        input  init_gnt, rd_en, rd_addr, win_shift, cmp_valid, cmp_row,
               wr_en, wr_addr, wr_bank, wr_src, front_bank, gen_busy, gen_count
    );
endinterface

// File: rtl/life_row_addr_gen.sv
// Modulo-ROWS row counter with toroidal neighbours: row, (row+2) mod ROWS, (row-1) mod ROWS.
// Latency: counter updates one cycle after clr/inc; neighbour outputs are combinational.
// Backpressure: none; advances only when inc is asserted.
// Ports: aclk/aresetn, clr (to row 0, wins over inc), inc, row, row_p2, row_m1.
module life_row_addr_gen #(
    parameter int ROWS   = 720,
    parameter int ROW_AW = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              inc,
    output logic [ROW_AW-1:0] row,
    output logic [ROW_AW-1:0] row_p2,
    output logic [ROW_AW-1:0] row_m1
);

    localparam logic [ROW_AW-1:0] LAST   = ROW_AW'(ROWS - 1);
    localparam logic [ROW_AW:0]   ROWS_W = (ROW_AW + 1)'(ROWS);

    logic [ROW_AW-1:0] row_q;
    logic [ROW_AW:0]   sum_p2;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            row_q <= '0;
        end else if (clr) begin
            row_q <= '0;
        end else if (inc) begin
            row_q <= (row_q == LAST) ? '0 : row_q + ROW_AW'(1);
        end
    end

    // One extra bit so row+2 cannot overflow before the modulo fold.
    always_comb begin
        sum_p2 = {1'b0, row_q} + (ROW_AW + 1)'(2);
        row_p2 = (sum_p2 >= ROWS_W) ? ROW_AW'(sum_p2 - ROWS_W) : ROW_AW'(sum_p2);
        row_m1 = (row_q == '0) ? LAST : row_q - ROW_AW'(1);
    end

    assign row = row_q;

endmodule

// File: rtl/life_gen_scheduler.sv
// Runs one Life generation per frame: preloads a toroidal 3-row window, per row waits for compute, writes back to the back bank.
// Latency: 4-cycle window preload, then 3 cycles + compute latency per row; bank swap lands on the frame_start after DONE.
// Backpressure: COMP holds indefinitely until cmp_ready; host writes wait for init_gnt, which is only given in IDLE.
// Ports: aclk, aresetn (async active-low), bus (master side of life_gen_scheduler_if).
module life_gen_scheduler #(
    parameter int ROWS   = 720,
    parameter int ROW_AW = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    life_gen_scheduler_if.master  bus
);
    import life_pkg::*;

    sched_state_t      state;
    sched_state_t      state_nxt;

    logic [ROW_AW-1:0] row;
    logic [ROW_AW-1:0] row_p2;
    logic [ROW_AW-1:0] row_m1_unused;
    logic              row_clr;
    logic              row_inc;

    logic              start;
    logic              swap_now;

    logic              front_bank_q;
    logic              swap_pending;
    logic              step_pending;
    logic              init_gnt_q;
    logic              win_shift_q;
    logic [31:0]       gen_count_q;

    logic              rd_en_c;
    logic [ROW_AW-1:0] rd_addr_c;
    logic              cmp_valid_c;
    logic [ROW_AW-1:0] cmp_row_c;
    logic              wr_en_c;
    logic [ROW_AW-1:0] wr_addr_c;
    logic              wr_bank_c;
    logic              wr_src_c;

    life_row_addr_gen #(
        .ROWS   (ROWS),
        .ROW_AW (ROW_AW)
    ) u_row_addr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (row_clr),
        .inc     (row_inc),
        .row     (row),
        .row_p2  (row_p2),
        .row_m1  (row_m1_unused)
    );

    always_comb begin
        state_nxt   = state;
        row_clr     = 1'b0;
        row_inc     = 1'b0;
        start       = 1'b0;
        swap_now    = 1'b0;
        rd_en_c     = 1'b0;
        rd_addr_c   = '0;
        cmp_valid_c = 1'b0;
        cmp_row_c   = '0;
        wr_en_c     = 1'b0;
        wr_addr_c   = '0;
        wr_bank_c   = 1'b0;
        wr_src_c    = WR_SRC_GEN;

        case (state)
            IDLE: begin
                // While the host owns the port the frame boundary is ignored;
                // the grant already discarded any pending swap.
                if (bus.frame_start && !init_gnt_q) begin
                    swap_now = swap_pending;
                    if ((!bus.pause || step_pending) && !bus.init_req) begin
                        start     = 1'b1;
                        row_clr   = 1'b1;
                        state_nxt = PRE0;
                    end
                end
            end
            PRE0: begin
                rd_en_c   = 1'b1;
                rd_addr_c = ROW_AW'(ROWS - 1);
                state_nxt = PRE1;
            end
            PRE1: begin
                rd_en_c   = 1'b1;
                rd_addr_c = '0;
                state_nxt = PRE2;
            end
            PRE2: begin
                rd_en_c   = 1'b1;
                rd_addr_c = ROW_AW'(1);
                state_nxt = PWAIT;
            end
            PWAIT: begin
                state_nxt = COMP;
            end
            COMP: begin
                cmp_valid_c = 1'b1;
                cmp_row_c   = row;
                if (bus.cmp_ready) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en_c   = 1'b1;
                wr_addr_c = row;
                wr_bank_c = ~front_bank_q;
                wr_src_c  = WR_SRC_GEN;
                state_nxt = (row == ROW_AW'(ROWS - 1)) ? DONE : FETCH;
            end
            FETCH: begin
                rd_en_c   = 1'b1;
                rd_addr_c = row_p2;
                row_inc   = 1'b1;
                state_nxt = COMP;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Grant only exists in IDLE, so this never collides with write-back.
        if (init_gnt_q) begin
            wr_en_c   = bus.init_we;
            wr_addr_c = bus.init_addr;
            wr_bank_c = front_bank_q;
            wr_src_c  = WR_SRC_HOST;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            front_bank_q <= 1'b0;
            swap_pending <= 1'b0;
            step_pending <= 1'b0;
            init_gnt_q   <= 1'b0;
            win_shift_q  <= 1'b0;
            gen_count_q  <= '0;
        end else begin
            state       <= state_nxt;
            // BRAM read latency is one cycle, so the window shifts the cycle after each read.
            win_shift_q <= rd_en_c;
            init_gnt_q  <= (state == IDLE) && bus.init_req;

            if (swap_now) begin
                front_bank_q <= ~front_bank_q;
            end

            if (state == DONE) begin
                swap_pending <= 1'b1;
            end else if (swap_now || init_gnt_q) begin
                swap_pending <= 1'b0;
            end

            // A step request made during a running generation is kept for the next frame.
            if (start) begin
                step_pending <= 1'b0;
            end else if (bus.step_req && bus.pause) begin
                step_pending <= 1'b1;
            end

            if (state == DONE) begin
                gen_count_q <= gen_count_q + 32'd1;
            end
        end
    end

    assign bus.init_gnt   = init_gnt_q;
    assign bus.rd_en      = rd_en_c;
    assign bus.rd_addr    = rd_addr_c;
    assign bus.win_shift  = win_shift_q;
    assign bus.cmp_valid  = cmp_valid_c;
    assign bus.cmp_row    = cmp_row_c;
    assign bus.wr_en      = wr_en_c;
    assign bus.wr_addr    = wr_addr_c;
    assign bus.wr_bank    = wr_bank_c;
    assign bus.wr_src     = wr_src_c;
    assign bus.front_bank = front_bank_q;
    assign bus.gen_busy   = (state != IDLE) && (state != DONE);
    assign bus.gen_count  = gen_count_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Self-checking bench for life_gen_scheduler on a 4-row grid.
// Frame-level reference model predicts bank, swap, step and count; monitors collect BRAM traffic.
// Table-driven frames, hand-written corner sequences, then randomized frames with host loads.
module tb_life_gen_scheduler;

    localparam int ROWS   = 4;
    localparam int ROW_AW = 10;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    life_gen_scheduler_if #(.ROW_AW(ROW_AW)) bus ();

    life_gen_scheduler #(
        .ROWS   (ROWS),
        .ROW_AW (ROW_AW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitored traffic
    int rd_q[$];
    int wa_q[$];
    bit wb_q[$];
    bit ws_q[$];
    int overlap_cnt = 0;
    int shift_err   = 0;
    bit prev_rd     = 1'b0;

    // Compute responder
    int cmp_cnt   = 0;
    int cmp_delay = 0;

    // Frame-level reference model
    bit m_front = 1'b0;
    bit m_swap  = 1'b0;
    bit m_step  = 1'b0;
    int m_count = 0;

    typedef struct {
        bit pause;
        bit step;
        int delay;
        bit exp_run;
        bit exp_front;
        int exp_count;
    } frame_vec_t;

    frame_vec_t vecs [9];

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_rd = 1'b0;
        end else begin
            if (bus.rd_en) rd_q.push_back(int'(bus.rd_addr));
            if (bus.wr_en) begin
                wa_q.push_back(int'(bus.wr_addr));
                wb_q.push_back(bus.wr_bank);
                ws_q.push_back(bus.wr_src);
            end
            if (bus.init_gnt && bus.gen_busy) overlap_cnt++;
            if (bus.win_shift !== prev_rd) shift_err++;
            prev_rd = bus.rd_en;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic service_cmp();
        if (bus.cmp_valid === 1'b1) begin
            cmp_cnt++;
            bus.cmp_ready = (cmp_cnt > cmp_delay);
        end else begin
            cmp_cnt = 0;
            bus.cmp_ready = 1'b0;
        end
    endtask

    task automatic step_cycle();
        tick();
        service_cmp();
    endtask

    task automatic clear_mon();
        rd_q.delete();
        wa_q.delete();
        wb_q.delete();
        ws_q.delete();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.gen_busy === 1'b1 && k < 400) begin
            step_cycle();
            k++;
        end
        check("gen_finish_in_budget", k < 400, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.init_gnt, bus.rd_en, bus.rd_addr, bus.win_shift, bus.cmp_valid, bus.cmp_row,
                    bus.wr_en, bus.wr_addr, bus.wr_bank, bus.wr_src, bus.front_bank, bus.gen_busy}, 0);
        check({tag, "_count"}, bus.gen_count, 0);
    endtask

    // Expected traffic of one generation: preload rows -1,0,1 then row r+2 after each
    // non-final row; every row written once, in order, to the hidden bank.
    task automatic check_traffic(input bit bank);
        int exp_rd[$];
        exp_rd.push_back(ROWS - 1);
        exp_rd.push_back(0);
        exp_rd.push_back(1);
        for (int r = 0; r < ROWS - 1; r++) exp_rd.push_back((r + 2) % ROWS);
        check("rd_count", rd_q.size(), exp_rd.size());
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
            check($sformatf("rd_addr[%0d]", i), rd_q[i], exp_rd[i]);
        check("wr_count", wa_q.size(), ROWS);
        for (int i = 0; i < wa_q.size() && i < ROWS; i++) begin
            check($sformatf("wr_addr[%0d]", i), wa_q[i], i);
            check($sformatf("wr_bank[%0d]", i), wb_q[i], bank);
            check($sformatf("wr_src[%0d]", i), ws_q[i], 1'b0);
        end
    endtask

    task automatic model_frame(input bit p, input bit s, output bit run, output bit front, output int count);
        if (s && p) m_step = 1'b1;
        if (m_swap) begin
            m_front = ~m_front;
            m_swap  = 1'b0;
        end
        run = !p || m_step;
        if (run) begin
            m_step = 1'b0;
            m_swap = 1'b1;
            m_count++;
        end
        front = m_front;
        count = m_count;
    endtask

    task automatic do_frame(input bit p, input bit s, input int d,
                            input bit exp_run, input bit exp_front, input int exp_count);
        bus.pause = p;
        if (s) begin
            bus.step_req = 1'b1;
            step_cycle();
            bus.step_req = 1'b0;
        end
        clear_mon();
        cmp_delay = d;
        bus.frame_start = 1'b1;
        step_cycle();
        bus.frame_start = 1'b0;
        check("front_at_sof", bus.front_bank, exp_front);
        check("gen_started", bus.gen_busy, exp_run);
        if (exp_run) begin
            wait_idle();
            check_traffic(~exp_front);
        end
        repeat (3) step_cycle();
        if (!exp_run) begin
            check("idle_rd_count", rd_q.size(), 0);
            check("idle_wr_count", wa_q.size(), 0);
        end
        check("gen_count", bus.gen_count, exp_count);
        check("front_hold", bus.front_bank, exp_front);
    endtask

    task automatic model_and_do(input bit p, input bit s, input int d);
        bit run;
        bit f;
        int c;
        model_frame(p, s, run, f, c);
        do_frame(p, s, d, run, f, c);
    endtask

    task automatic host_init();
        int n;
        int addrs[$];
        bus.init_req = 1'b1;
        step_cycle();
        check("host_gnt", bus.init_gnt, 1'b1);
        clear_mon();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            addrs.push_back($urandom_range(0, ROWS - 1));
            bus.init_we   = 1'b1;
            bus.init_addr = ROW_AW'(addrs[i]);
            step_cycle();
        end
        bus.init_we = 1'b0;
        step_cycle();
        check("host_wr_count", wa_q.size(), n);
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            check("host_wr_addr", wa_q[i], addrs[i]);
            check("host_wr_bank", wb_q[i], m_front);
            check("host_wr_src", ws_q[i], 1'b1);
        end
        bus.init_req = 1'b0;
        m_swap = 1'b0;
        repeat (2) step_cycle();
        check("host_gnt_release", bus.init_gnt, 1'b0);
    endtask

    initial begin
        bit run;
        bit f;
        int c;
        int k;
        int early;
        int viol;
        logic [ROW_AW-1:0] row0;

        bus.frame_start = 1'b0;
        bus.pause       = 1'b0;
        bus.step_req    = 1'b0;
        bus.init_req    = 1'b0;
        bus.init_we     = 1'b0;
        bus.init_addr   = '0;
        bus.cmp_ready   = 1'b0;

        //                pause step delay run front count
        vecs[0] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 2};
        vecs[2] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2};
        vecs[4] = '{1'b1, 1'b1, 3, 1'b1, 1'b0, 3};
        vecs[5] = '{1'b1, 1'b0, 1, 1'b0, 1'b1, 3};
        vecs[6] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 4};
        vecs[7] = '{1'b1, 1'b0, 2, 1'b0, 1'b0, 4};
        vecs[8] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 5};

        repeat (3) @(posedge aclk);
        #1;
        check_all_zero("reset_outputs");
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        check_all_zero("after_release");

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            model_frame(vecs[i].pause, vecs[i].step, run, f, c);
            do_frame(vecs[i].pause, vecs[i].step, vecs[i].delay,
                     vecs[i].exp_run, vecs[i].exp_front, vecs[i].exp_count);
        end

        // init_req coincident with frame_start while a swap is pending
        bus.pause = 1'b0;
        clear_mon();
        bus.init_req    = 1'b1;
        bus.frame_start = 1'b1;
        step_cycle();
        bus.frame_start = 1'b0;
        m_front = ~m_front;
        m_swap  = 1'b0;
        check("coinc_front_toggle", bus.front_bank, m_front);
        check("coinc_gnt", bus.init_gnt, 1'b1);
        check("coinc_no_gen", bus.gen_busy, 1'b0);
        repeat (3) step_cycle();
        check("coinc_no_reads", rd_q.size(), 0);
        check("coinc_gen_idle", bus.gen_busy, 1'b0);
        bus.init_req = 1'b0;
        repeat (2) step_cycle();

        // init_req raised mid-generation
        bus.pause = 1'b0;
        model_frame(1'b0, 1'b0, run, f, c);
        clear_mon();
        cmp_delay = 1;
        bus.frame_start = 1'b1;
        step_cycle();
        bus.frame_start = 1'b0;
        check("midinit_started", bus.gen_busy, 1'b1);
        early = 0;
        k = 0;
        while (bus.gen_busy === 1'b1 && k < 400) begin
            if (bus.cmp_valid === 1'b1 && bus.cmp_row == ROW_AW'(2)) bus.init_req = 1'b1;
            if (bus.init_gnt === 1'b1) early++;
            step_cycle();
            k++;
        end
        check("midinit_budget", k < 400, 1'b1);
        check("midinit_gnt_during_gen", early, 0);
        check("midinit_req_seen", bus.init_req, 1'b1);
        check_traffic(~f);
        k = 0;
        while (bus.init_gnt !== 1'b1 && k < 10) begin
            step_cycle();
            k++;
        end
        check("midinit_gnt_after_done", bus.init_gnt, 1'b1);
        check("midinit_count", bus.gen_count, c);
        m_swap = 1'b0;
        clear_mon();
        bus.init_we   = 1'b1;
        bus.init_addr = ROW_AW'(2);
        step_cycle();
        bus.init_we = 1'b0;
        step_cycle();
        check("midinit_wr_count", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            check("midinit_wr_addr", wa_q[0], 2);
            check("midinit_wr_bank", wb_q[0], m_front);
            check("midinit_wr_src", ws_q[0], 1'b1);
        end
        bus.init_req = 1'b0;
        repeat (2) step_cycle();
        check("midinit_gnt_release", bus.init_gnt, 1'b0);
        model_and_do(1'b1, 1'b0, 0);

        // cmp_ready withheld for 50 cycles
        model_frame(1'b0, 1'b0, run, f, c);
        clear_mon();
        cmp_delay = 100000;
        bus.pause = 1'b0;
        bus.frame_start = 1'b1;
        step_cycle();
        bus.frame_start = 1'b0;
        k = 0;
        while (bus.cmp_valid !== 1'b1 && k < 20) begin
            step_cycle();
            k++;
        end
        check("hold_reach_comp", bus.cmp_valid, 1'b1);
        row0 = bus.cmp_row;
        check("hold_first_row", row0, 0);
        viol = 0;
        repeat (50) begin
            step_cycle();
            if (bus.cmp_valid !== 1'b1 || bus.cmp_row !== row0 || bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0)
                viol++;
        end
        check("hold_violations", viol, 0);
        cmp_delay = 0;
        wait_idle();
        check_traffic(~f);
        repeat (3) step_cycle();
        check("hold_count", bus.gen_count, c);

        // Randomized frames against the model
        for (int i = 0; i < 20; i++) begin
            bit rp;
            bit rs;
            int rd;
            if ($urandom_range(0, 3) == 0) host_init();
            rp = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rd = $urandom_range(0, 4);
            model_and_do(rp, rs, rd);
        end

        // Asynchronous reset during FETCH of row 1
        bus.pause = 1'b0;
        clear_mon();
        cmp_delay = 1;
        bus.frame_start = 1'b1;
        step_cycle();
        bus.frame_start = 1'b0;
        k = 0;
        while (!(bus.rd_en === 1'b1 && wa_q.size() == 2) && k < 100) begin
            step_cycle();
            k++;
        end
        check("rst_reach_fetch_row1", k < 100, 1'b1);
        check("rst_fetch_addr", bus.rd_addr, 3);
        #2;
        aresetn = 1'b0;
        #1;
        check_all_zero("rst_async_mid_gen");
        bus.cmp_ready = 1'b0;
        cmp_cnt = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        m_front = 1'b0;
        m_swap  = 1'b0;
        m_step  = 1'b0;
        m_count = 0;
        check_all_zero("rst_after_release");
        model_and_do(1'b0, 1'b0, 1);

        check("gnt_busy_overlap", overlap_cnt, 0);
        check("win_shift_alignment", shift_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
